// File: rtl/prio_enc8to3_if.sv
// Request/grant bundle for the 8-to-3 priority encoder.
// master = encoder side; slave = requester/consumer side.
interface prio_enc8to3_if;
  logic [7:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic [7:0] pending;

  modport master (
    input  req,
    input  out_ready,
    output out_valid,
    output out_code,
    output pending
  );

  modport slave (
    output req,
    output out_ready,
    input  out_valid,
    input  out_code,
    input  pending
  );
endinterface

// File: rtl/prio_enc8to3.sv
// Registered 8-to-3 priority encoder with sticky pending bits.
// Ports: clk, rst (sync, active high), bus (req/out_ready in;
// out_valid/out_code/pending out). ROUND_ROBIN selects rotation.
module prio_enc8to3 #(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input logic            clk,
  input logic            rst,
  prio_enc8to3_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] code_q;
  logic [2:0] last_q;
  logic [7:0] pend_q;
  logic [7:0] pend_d;
  logic [7:0] clr;
  logic [2:0] base;
  logic [2:0] fx_code;
  logic [2:0] rr_code;
  logic [2:0] win;
  logic       hs;
  logic       load;

  assign hs     = (state_q == HOLD) & bus.out_ready;
  assign clr    = hs ? (8'b1 << code_q) : 8'h00;
  // set wins over clear for a same-cycle re-request
  assign pend_d = (pend_q & ~clr) | bus.req;
  assign load   = (state_q == IDLE) | hs;
  // pointer as it will be after this edge
  assign base   = hs ? code_q : last_q;

  // highest set index wins
  always_comb begin
    fx_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_d[i]) fx_code = 3'(i);
    end
  end

  // scan base+8 down to base+1; closest to base+1 wins,
  // base itself (offset 8) is searched last
  always_comb begin
    rr_code = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      if (pend_d[base + 3'(i)]) rr_code = base + 3'(i);
    end
  end

  assign win = ROUND_ROBIN ? rr_code : fx_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
      last_q  <= 3'd7;
      pend_q  <= 8'h00;
    end else begin
      pend_q <= pend_d;
      if (hs) last_q <= code_q;
      if (load) begin
        if (|pend_d) begin
          state_q <= HOLD;
          code_q  <= win;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_code  = code_q;
  assign bus.pending   = pend_q;

endmodule

// File: doc/prio_enc8to3.md
# prio_enc8to3

Registered 8-to-3 priority encoder with request latching and a valid/ready output. Eight request lines set sticky pending bits. The block presents the index of the winning pending bit as a 3-bit binary code and clears that bit when the consumer accepts it. It is the encoding counterpart of the 3-to-8 one-hot decoder, for use as an interrupt/request concentrator ahead of logic that consumes a binary select.

## Interface
- ROUND_ROBIN, default 0: 0 = fixed priority with index 7 highest; 1 = rotating priority.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request pulses or levels, sampled every cycle; bit i sets pending[i].
- out_ready  input  1  consumer accepts out_code when high together with out_valid.
- out_valid  output  1  out_code holds a granted request.
- out_code  output  3  binary index of the granted request.
- pending  output  8  current sticky pending register.

## Operation
- Handshake: `hs = out_valid & out_ready`. Clear mask `clr = hs ? (8'b1 << out_code) : 8'h00`.
- Pending update every cycle: `pending_next = (pending & ~clr) | req`.
  - Set wins over clear: a bit requested in the same cycle it is accepted stays pending.
  - Re-requesting an already-pending bit has no effect. There is no counting.
- Output register, two states:
  - IDLE: out_valid=0.
  - HOLD: out_valid=1, out_code stable.
- Selection is computed from the candidate vector `cand = pending_next & ~(hs ? 8'h00 : 8'h00)`, i.e. `pending_next`. Only a bit that is both granted and re-requested can reappear.
- Load rule: when `out_valid==0` or `hs==1`:
  - If `cand != 0`: load out_code with the winner and set out_valid=1 (enter or stay in HOLD).
  - Otherwise: out_valid=0 and enter IDLE. out_code keeps its last value.
- While `out_valid & ~out_ready`: out_code and out_valid hold. A newly arriving higher-priority request does not preempt; it only sets pending.
- Fixed priority (ROUND_ROBIN=0): the winner is the highest set index of cand.
- Round-robin (ROUND_ROBIN=1):
  - 3-bit pointer `last`, updated to out_code on every hs.
  - Search order is last+1, last+2, …, last+8, all modulo 8 (wrap from 7 to 0). The first set bit of cand wins.
  - The just-granted index is searched last.
- The granted bit remains set in pending while it is held and is cleared only on hs.

## Timing
- Reset values: pending=8'h00, out_valid=0, out_code=3'd0, last=3'd7 (first round-robin search starts at index 0).
- Reset has priority over everything. Asserting rst during HOLD drops out_valid on the next edge and discards all pending and in-flight requests. req sampled in the reset cycle is ignored.
- Latency: req bit asserted in cycle N with the block in IDLE gives out_valid=1 and out_code valid from the edge ending cycle N (visible in cycle N+1).
- Throughput: one grant per cycle with out_ready held high and pending non-empty. There are no bubbles between grants.
- After the last pending bit is accepted and no new req arrives, out_valid falls on that same handshake edge.
- out_valid/out_code are pure register outputs with no combinational path from req or out_ready.
- pending reflects requests one cycle after req is asserted.

## Test plan
- Idle: reset for 2 cycles, then req=8'h00 for 10 cycles → out_valid=0, out_code=0, pending=8'h00 throughout.
- Fixed priority, ROUND_ROBIN=0:
  - Stimulus: req=8'h24 for one cycle, out_ready=1.
  - Required: next cycle out_code=5 (pending=8'h24); following cycle out_code=2 (pending=8'h04); then out_valid=0 and pending=8'h00.
- Backpressure:
  - Stimulus: req=8'h08, out_ready=0 for 5 cycles; during HOLD pulse req=8'h40.
  - Required: out_code stays 3 and pending=8'h48.
  - Then raise out_ready: code 3 is accepted, then code 6, then out_valid=0.
- Round-robin, ROUND_ROBIN=1: req=8'hFF held, out_ready=1 → out_code sequence 0,1,2,3,4,5,6,7,0,1 on consecutive cycles, with out_valid continuously 1.
- Set/clear collision, fixed priority:
  - Stimulus: hold code 7, then assert req=8'h80 in the same cycle as the handshake.
  - Required: pending[7] stays 1, out_code=7 again next cycle with out_valid=1, and a total of two acceptances of code 7 are observed.
- Reset mid-operation:
  - Stimulus: with pending=8'h7E and out_valid=1, assert rst for one cycle while req=8'h01.
  - Required: next cycle out_valid=0 and pending=8'h00. With ROUND_ROBIN=1, a subsequent req=8'h81 grants 0 first.
